// File: rtl/llc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : llc_mem_arbiter
// Brief    : Shares one cacheline-adaptor port between the I-cache (read-only)
//            and the D-cache (read/write). One full line transaction at a time,
//            round-robin on ties, with a sticky hung-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module llc_mem_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [31:0]       i_addr_i,
    input  logic              i_read_i,
    output logic [s_line-1:0] i_line_o,
    output logic              i_resp_o,

    input  logic [31:0]       d_addr_i,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [s_line-1:0] d_line_i,
    output logic [s_line-1:0] d_line_o,
    output logic              d_resp_o,

    output logic [31:0]       ca_addr_o,
    output logic              ca_read_o,
    output logic              ca_write_o,
    output logic [s_line-1:0] ca_line_o,
    input  logic [s_line-1:0] ca_line_i,
    input  logic              ca_resp_i,

    output logic              busy_o,
    output logic              timeout_o
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_gnt_i   = 2'd1;
    localparam logic [1:0] c_st_gnt_d   = 2'd2;
    localparam logic [1:0] c_st_recover = 2'd3;

    localparam logic c_last_i = 1'b0;
    localparam logic c_last_d = 1'b1;

    localparam logic [WDOG_W-1:0] c_wdog_limit = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] c_wdog_max   = WDOG_W'(TIMEOUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_last_gnt;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_in_grant;
    logic [31:0]       w_i_line_addr;
    logic [31:0]       w_d_line_addr;
    logic              w_unused_addr_bits;

    assign w_i_req    = i_read_i;
    assign w_d_req    = d_read_i | d_write_i;
    assign w_in_grant = (r_state == c_st_gnt_i) || (r_state == c_st_gnt_d);

    // The adaptor works on whole lines, so the byte offset is always dropped.
    assign w_i_line_addr      = {i_addr_i[31:s_offset], {s_offset{1'b0}}};
    assign w_d_line_addr      = {d_addr_i[31:s_offset], {s_offset{1'b0}}};
    assign w_unused_addr_bits = ^{i_addr_i[s_offset-1:0], d_addr_i[s_offset-1:0]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_i_req && w_d_req) begin
                    w_state_next = (r_last_gnt == c_last_d) ? c_st_gnt_i : c_st_gnt_d;
                end else if (w_i_req) begin
                    w_state_next = c_st_gnt_i;
                end else if (w_d_req) begin
                    w_state_next = c_st_gnt_d;
                end
            end
            c_st_gnt_i,
            c_st_gnt_d: begin
                if (ca_resp_i) begin
                    w_state_next = c_st_recover;
                end
            end
            c_st_recover: w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_last_gnt <= c_last_d;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == c_st_idle && w_state_next == c_st_gnt_i) begin
                r_last_gnt <= c_last_i;
            end else if (r_state == c_st_idle && w_state_next == c_st_gnt_d) begin
                r_last_gnt <= c_last_d;
            end

            // Watchdog only reports; the grant stays put so a late resp still completes.
            if (w_in_grant) begin
                if (r_wdog != c_wdog_max) begin
                    r_wdog <= r_wdog + 1'b1;
                end
                if (r_wdog == c_wdog_limit && !ca_resp_i) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wdog <= '0;
            end
        end
    end

    always_comb begin
        ca_addr_o  = '0;
        ca_read_o  = 1'b0;
        ca_write_o = 1'b0;
        ca_line_o  = '0;
        i_resp_o   = 1'b0;
        i_line_o   = '0;
        d_resp_o   = 1'b0;
        d_line_o   = '0;
        case (r_state)
            c_st_gnt_i: begin
                ca_addr_o = w_i_line_addr;
                ca_read_o = 1'b1;
                if (ca_resp_i) begin
                    i_resp_o = 1'b1;
                    i_line_o = ca_line_i;
                end
            end
            c_st_gnt_d: begin
                ca_addr_o  = w_d_line_addr;
                ca_write_o = d_write_i;
                ca_read_o  = d_read_i & ~d_write_i;
                ca_line_o  = d_line_i;
                if (ca_resp_i) begin
                    d_resp_o = 1'b1;
                    d_line_o = ca_line_i;
                end
            end
            default: ;
        endcase
    end

    assign busy_o    = (r_state != c_st_idle);
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_llc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_llc_mem_arbiter
// Brief    : Directed plus randomized bench for llc_mem_arbiter with a
//            transaction-level reference model of ownership and round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llc_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  i_addr_i = '0;
    logic         i_read_i = 1'b0;
    logic [255:0] i_line_o;
    logic         i_resp_o;
    logic [31:0]  d_addr_i = '0;
    logic         d_read_i = 1'b0;
    logic         d_write_i = 1'b0;
    logic [255:0] d_line_i = '0;
    logic [255:0] d_line_o;
    logic         d_resp_o;
    logic [31:0]  ca_addr_o;
    logic         ca_read_o;
    logic         ca_write_o;
    logic [255:0] ca_line_o;
    logic [255:0] ca_line_i = '0;
    logic         ca_resp_i = 1'b0;
    logic         busy_o;
    logic         timeout_o;

    // Model: owner 0=none 1=I 2=D; last 1=I 2=D
    int m_owner, m_last, m_wait;
    bit m_rec, m_to, served_i, served_d;
    int errors = 0;
    int checks = 0;

    llc_mem_arbiter #(.s_offset(5), .s_line(256), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_addr_i(i_addr_i), .i_read_i(i_read_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
        .d_addr_i(d_addr_i), .d_read_i(d_read_i), .d_write_i(d_write_i), .d_line_i(d_line_i),
        .d_line_o(d_line_o), .d_resp_o(d_resp_o),
        .ca_addr_o(ca_addr_o), .ca_read_o(ca_read_o), .ca_write_o(ca_write_o),
        .ca_line_o(ca_line_o), .ca_line_i(ca_line_i), .ca_resp_i(ca_resp_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model, then let the model take the coming edge.
    task automatic check_cycle();
        logic [31:0]  e_addr;
        logic         e_rd, e_wr, e_ir, e_dr;
        logic [255:0] e_cal, e_il, e_dl;
        @(negedge clk);
        e_addr = '0; e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0;
        e_cal = '0; e_il = '0; e_dl = '0;
        if (m_owner == 1) begin
            e_rd   = 1'b1;
            e_addr = i_addr_i & 32'hFFFF_FFE0;
            e_ir   = ca_resp_i;
            if (ca_resp_i) e_il = ca_line_i;
        end else if (m_owner == 2) begin
            e_wr   = d_write_i;
            e_rd   = d_read_i && !d_write_i;
            e_addr = d_addr_i & 32'hFFFF_FFE0;
            e_cal  = d_line_i;
            e_dr   = ca_resp_i;
            if (ca_resp_i) e_dl = ca_line_i;
        end
        chk("busy",      256'(busy_o),     256'(m_owner != 0 || m_rec));
        chk("timeout",   256'(timeout_o),  256'(m_to));
        chk("ca_read",   256'(ca_read_o),  256'(e_rd));
        chk("ca_write",  256'(ca_write_o), 256'(e_wr));
        chk("ca_addr",   256'(ca_addr_o),  256'(e_addr));
        chk("ca_line_o", ca_line_o,        e_cal);
        chk("i_resp",    256'(i_resp_o),   256'(e_ir));
        chk("i_line",    i_line_o,         e_il);
        chk("d_resp",    256'(d_resp_o),   256'(e_dr));
        chk("d_line",    d_line_o,         e_dl);

        if (m_owner != 0) begin
            if (ca_resp_i) begin
                if (m_owner == 1) served_i = 1; else served_d = 1;
                m_owner = 0;
                m_rec   = 1;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) m_to = 1;
            end
        end else if (m_rec) begin
            m_rec = 0;
        end else begin
            if (i_read_i && (d_read_i || d_write_i)) m_owner = (m_last == 1) ? 2 : 1;
            else if (i_read_i) m_owner = 1;
            else if (d_read_i || d_write_i) m_owner = 2;
            if (m_owner != 0) begin
                m_last = m_owner;
                m_wait = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ca_read",  256'(ca_read_o),  256'(0));
        chk("rst_ca_write", 256'(ca_write_o), 256'(0));
        chk("rst_ca_addr",  256'(ca_addr_o),  256'(0));
        chk("rst_ca_line",  ca_line_o,        256'(0));
        chk("rst_i_resp",   256'(i_resp_o),   256'(0));
        chk("rst_d_resp",   256'(d_resp_o),   256'(0));
        chk("rst_busy",     256'(busy_o),     256'(0));
        chk("rst_timeout",  256'(timeout_o),  256'(0));
        m_owner = 0; m_last = 2; m_wait = 0;
        m_rec = 0; m_to = 0; served_i = 0; served_d = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic random_drive(input bit allow_new);
        int kind;
        if (served_i) begin
            i_read_i = 0; served_i = 0;
        end else if (allow_new && !i_read_i && $urandom_range(0, 2) == 0) begin
            i_read_i = 1; i_addr_i = $urandom;
        end
        if (served_d) begin
            d_read_i = 0; d_write_i = 0; served_d = 0;
        end else if (allow_new && !(d_read_i || d_write_i) && $urandom_range(0, 2) == 0) begin
            kind      = int'($urandom_range(0, 2));
            d_read_i  = (kind != 1);
            d_write_i = (kind != 0);
            d_addr_i  = $urandom;
            d_line_i  = rand_line();
        end
        ca_line_i = rand_line();
        ca_resp_i = (m_owner != 0) && ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        logic [255:0] pat_a, pat_b, pat_c;
        pat_a = rand_line();
        pat_b = rand_line();
        pat_c = rand_line();

        #3;
        do_reset();

        // I-only line read
        i_read_i = 1; i_addr_i = 32'h0000_1234; check_cycle();
        advance(); check_cycle();
        chk("t1_ca_read", 256'(ca_read_o), 256'(1));
        chk("t1_ca_addr", 256'(ca_addr_o), 256'(32'h0000_1220));
        advance(); ca_resp_i = 1; ca_line_i = pat_a; check_cycle();
        chk("t1_i_resp", 256'(i_resp_o), 256'(1));
        chk("t1_i_line", i_line_o, pat_a);
        chk("t1_d_resp", 256'(d_resp_o), 256'(0));
        advance(); ca_resp_i = 0; i_read_i = 0; check_cycle();
        chk("t1_i_resp_pulse", 256'(i_resp_o), 256'(0));
        advance(); check_cycle();

        // D writeback
        advance(); d_write_i = 1; d_addr_i = 32'h8000_0040; d_line_i = pat_b; check_cycle();
        advance(); check_cycle();
        chk("t2_ca_write", 256'(ca_write_o), 256'(1));
        chk("t2_ca_read",  256'(ca_read_o),  256'(0));
        chk("t2_ca_line",  ca_line_o,        pat_b);
        advance(); ca_resp_i = 1; ca_line_i = pat_c; check_cycle();
        chk("t2_d_resp", 256'(d_resp_o), 256'(1));
        advance(); ca_resp_i = 0; d_write_i = 0; check_cycle();
        chk("t2_recover_write", 256'(ca_write_o), 256'(0));
        chk("t2_recover_busy",  256'(busy_o),     256'(1));
        advance(); check_cycle();

        // Ties: I wins each tie because D was always served last
        for (int t = 0; t < 4; t++) begin
            advance(); i_read_i = 1; d_read_i = 1;
            i_addr_i = 32'h0000_1000; d_addr_i = 32'h0000_2000; check_cycle();
            advance(); check_cycle();
            chk("t3_first_is_i", 256'(ca_addr_o), 256'(32'h0000_1000));
            advance(); ca_resp_i = 1; ca_line_i = rand_line(); check_cycle();
            advance(); ca_resp_i = 0; i_read_i = 0; check_cycle();
            advance(); check_cycle();
            advance(); check_cycle();
            chk("t3_second_is_d", 256'(ca_addr_o), 256'(32'h0000_2000));
            advance(); ca_resp_i = 1; ca_line_i = rand_line(); check_cycle();
            advance(); ca_resp_i = 0; d_read_i = 0; check_cycle();
            advance(); check_cycle();
        end

        // Read and write both high: write wins
        advance(); d_read_i = 1; d_write_i = 1; d_addr_i = 32'h0000_3000; d_line_i = pat_c; check_cycle();
        advance(); check_cycle();
        chk("t4_ca_write", 256'(ca_write_o), 256'(1));
        chk("t4_ca_read",  256'(ca_read_o),  256'(0));
        advance(); ca_resp_i = 1; check_cycle();
        advance(); ca_resp_i = 0; d_read_i = 0; d_write_i = 0; check_cycle();
        advance(); check_cycle();

        // Randomized traffic
        served_i = 0; served_d = 0;
        for (int c = 0; c < 400; c++) begin
            advance(); random_drive(1'b1); check_cycle();
        end
        for (int c = 0; c < 200 && (i_read_i || d_read_i || d_write_i || m_owner != 0 || m_rec); c++) begin
            advance(); random_drive(1'b0); check_cycle();
        end
        chk("drain_done", 256'(m_owner == 0 && !m_rec), 256'(1));
        advance(); ca_resp_i = 0; check_cycle();

        // Hung transaction
        advance();
        i_read_i = 0; d_read_i = 0; d_write_i = 0; ca_resp_i = 0;
        do_reset();
        i_read_i = 1; i_addr_i = 32'h0000_4000; check_cycle();
        for (int k = 1; k <= TIMEOUT; k++) begin
            advance(); check_cycle();
            chk("t5_timeout_early", 256'(timeout_o), 256'(0));
        end
        advance(); check_cycle();
        chk("t5_timeout_set",  256'(timeout_o), 256'(1));
        chk("t5_grant_held",   256'(ca_read_o), 256'(1));
        advance(); ca_resp_i = 1; check_cycle();
        advance(); ca_resp_i = 0; i_read_i = 0; check_cycle();
        chk("t5_timeout_sticky", 256'(timeout_o), 256'(1));
        advance(); check_cycle();

        // Reset in the middle of a D grant
        advance(); d_read_i = 1; d_addr_i = 32'h0000_5000; check_cycle();
        advance(); i_read_i = 1; i_addr_i = 32'h0000_6000; check_cycle();
        chk("t6_d_granted", 256'(ca_addr_o), 256'(32'h0000_5000));
        advance(); #2;
        do_reset();
        check_cycle();
        advance(); check_cycle();
        chk("t6_i_first", 256'(ca_addr_o), 256'(32'h0000_6000));
        advance(); ca_resp_i = 1; check_cycle();
        advance(); ca_resp_i = 0; i_read_i = 0; check_cycle();
        advance(); check_cycle();
        advance(); check_cycle();
        chk("t6_d_after", 256'(ca_addr_o), 256'(32'h0000_5000));
        advance(); ca_resp_i = 1; check_cycle();
        advance(); ca_resp_i = 0; d_read_i = 0; check_cycle();
        advance(); check_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
